// File: rtl/dmem_access_arbiter.sv
// Data-memory access arbiter between the core load/store path and the loader port.
// One access at a time: arbitrate in IDLE, strobe memory in ISSUE, wait out the
// read latency in WAIT, pulse the owner's ack in RESP.
module dmem_access_arbiter #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_ack,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_ack,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   localparam int unsigned LAT_W    = 3;
   localparam int unsigned STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(MEM_LAT - 1);
   localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                we_q, we_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                owner_q, owner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
   logic [DATA_W-1:0]   ldr_rdata_q, ldr_rdata_d;
   logic                rd_en_q, rd_en_d;
   logic                wr_en_q, wr_en_d;
   logic                busy_q, busy_d;
   logic                core_ack_q, core_ack_d;
   logic                ldr_ack_q, ldr_ack_d;
   logic                grant_ldr_c;

   // State and output registers; reset abandons any access in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         we_q         <= 1'b0;
         lat_q        <= '0;
         starve_q     <= '0;
         owner_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         core_rdata_q <= '0;
         ldr_rdata_q  <= '0;
         rd_en_q      <= 1'b0;
         wr_en_q      <= 1'b0;
         busy_q       <= 1'b0;
         core_ack_q   <= 1'b0;
         ldr_ack_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         lat_q        <= lat_d;
         starve_q     <= starve_d;
         owner_q      <= owner_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         core_rdata_q <= core_rdata_d;
         ldr_rdata_q  <= ldr_rdata_d;
         rd_en_q      <= rd_en_d;
         wr_en_q      <= wr_en_d;
         busy_q       <= busy_d;
         core_ack_q   <= core_ack_d;
         ldr_ack_q    <= ldr_ack_d;
      end
   end

   // Next-state, arbitration and next-output logic; outputs are set one cycle ahead.
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      lat_d        = lat_q;
      starve_d     = starve_q;
      owner_d      = owner_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      core_rdata_d = core_rdata_q;
      ldr_rdata_d  = ldr_rdata_q;
      rd_en_d      = 1'b0;
      wr_en_d      = 1'b0;
      grant_ldr_c  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!ldr_req) starve_d = '0;
            if (core_req || ldr_req) begin
               // Core has priority unless the loader has been passed over too often.
               grant_ldr_c = ldr_req && (!core_req || (starve_q == STARVE_TOP));
               if (grant_ldr_c) begin
                  owner_d  = 1'b1;
                  we_d     = ldr_we;
                  addr_d   = ldr_addr;
                  wdata_d  = ldr_wdata;
                  starve_d = '0;
               end else begin
                  owner_d = 1'b0;
                  we_d    = core_we;
                  addr_d  = core_addr;
                  wdata_d = core_wdata;
                  if (ldr_req && (starve_q != STARVE_TOP)) starve_d = starve_q + STARVE_W'(1);
               end
               rd_en_d = !we_d;
               wr_en_d = we_d;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            lat_d   = LAT_LOAD;
            state_d = we_q ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            if (lat_q == '0) begin
               if (owner_q) ldr_rdata_d = mem_rdata;
               else         core_rdata_d = mem_rdata;
               state_d = S_RESP;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d     = (state_d != S_IDLE);
      core_ack_d = (state_d == S_RESP) && !owner_d;
      ldr_ack_d  = (state_d == S_RESP) && owner_d;
   end

   assign core_ack   = core_ack_q;
   assign ldr_ack    = ldr_ack_q;
   assign core_rdata = core_rdata_q;
   assign ldr_rdata  = ldr_rdata_q;
   assign mem_rd_en  = rd_en_q;
   assign mem_wr_en  = wr_en_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign busy       = busy_q;
   assign owner      = owner_q;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Bench for dmem_access_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of grants, latencies and memory contents.
`timescale 1ns/1ps
module tb_dmem_access_arbiter;

   localparam int DW   = 16;
   localparam int AW   = 8;
   localparam int LAT  = 3;
   localparam int SMAX = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          core_req, core_we, core_ack;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata, core_rdata;
   logic          ldr_req, ldr_we, ldr_ack;
   logic [AW-1:0] ldr_addr;
   logic [DW-1:0] ldr_wdata, ldr_rdata;
   logic          mem_rd_en, mem_wr_en;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          busy, owner;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dmem_access_arbiter #(
      .DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)
   ) u_dut (
      .clk(clk), .reset(reset),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_ack(core_ack), .core_rdata(core_rdata),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .owner(owner)
   );

   // Memory model: never-written words read back a fixed address-derived pattern.
   function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
      return {a, ~a};
   endfunction

   logic [DW-1:0] tb_mem [256];
   bit            tb_vld [256];
   logic          rd_pend;
   int            rd_cnt;
   logic [AW-1:0] rd_addr;

   always @(posedge clk) begin
      if (!reset && mem_wr_en) begin
         tb_mem[mem_addr] <= mem_wdata;
         tb_vld[mem_addr] <= 1'b1;
      end
   end

   // Read data is presented only in the cycle MEM_LAT cycles after the strobe.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_pend <= 1'b0;
         rd_cnt  <= 0;
         rd_addr <= '0;
      end else if (mem_rd_en) begin
         rd_pend <= 1'b1;
         rd_cnt  <= LAT - 1;
         rd_addr <= mem_addr;
      end else if (rd_pend) begin
         if (rd_cnt == 0) rd_pend <= 1'b0;
         else             rd_cnt  <= rd_cnt - 1;
      end
   end

   assign mem_rdata = (rd_pend && rd_cnt == 0) ?
                      (tb_vld[rd_addr] ? tb_mem[rd_addr] : mem_init(rd_addr)) : 16'hDEAD;

   task automatic test_reset();
      reset = 1'b1;
      core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
      ldr_req  = 1'b0; ldr_we  = 1'b0; ldr_addr  = '0; ldr_wdata  = '0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({core_ack, ldr_ack, mem_rd_en, mem_wr_en, busy, owner} !== 6'b0 ||
          mem_addr !== 8'h00 || mem_wdata !== 16'h0000 ||
          core_rdata !== 16'h0000 || ldr_rdata !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_outputs: acks=%b%b rd=%b wr=%b busy=%b owner=%b addr=%h wdata=%h crd=%h lrd=%h, expected all zero",
                  core_ack, ldr_ack, mem_rd_en, mem_wr_en, busy, owner, mem_addr, mem_wdata, core_rdata, ldr_rdata);
      end
      reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || core_ack !== 1'b0 || ldr_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b acks=%b%b, expected 0 00", busy, core_ack, ldr_ack);
      end
   endtask

   task automatic test_core_write();
      core_req = 1'b1; core_we = 1'b1; core_addr = 8'h12; core_wdata = 16'hBEEF;
      @(negedge clk);
      n_tests++;
      if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0 || mem_addr !== 8'h12 || mem_wdata !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL cw_issue: wr=%b rd=%b addr=%h wdata=%h, expected wr=1 rd=0 addr=12 wdata=beef",
                  mem_wr_en, mem_rd_en, mem_addr, mem_wdata);
      end
      n_tests++;
      if (busy !== 1'b1 || core_ack !== 1'b0 || owner !== 1'b0) begin
         n_fail++;
         $display("FAIL cw_busy1: busy=%b ack=%b owner=%b, expected 1 0 0", busy, core_ack, owner);
      end
      @(negedge clk);
      n_tests++;
      if (core_ack !== 1'b1 || ldr_ack !== 1'b0 || busy !== 1'b1 || mem_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL cw_ack: core_ack=%b ldr_ack=%b busy=%b wr=%b, expected 1 0 1 0",
                  core_ack, ldr_ack, busy, mem_wr_en);
      end
      core_req = 1'b0;
      @(negedge clk);
      n_tests++;
      if (core_ack !== 1'b0 || busy !== 1'b0 || mem_addr !== 8'h12) begin
         n_fail++;
         $display("FAIL cw_done: ack=%b busy=%b addr=%h, expected 0 0 12", core_ack, busy, mem_addr);
      end
   endtask

   task automatic test_core_read();
      core_req = 1'b1; core_we = 1'b0; core_addr = 8'h12; core_wdata = 16'h0000;
      for (int c = 1; c <= 2 + LAT; c++) begin
         @(negedge clk);
         n_tests++;
         if (mem_rd_en !== (c == 1) || mem_wr_en !== 1'b0 || core_ack !== (c == 2 + LAT) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cr_cycle%0d: rd=%b wr=%b ack=%b busy=%b, expected rd=%b wr=0 ack=%b busy=1",
                     c, mem_rd_en, mem_wr_en, core_ack, busy, c == 1, c == 2 + LAT);
         end
      end
      n_tests++;
      if (core_rdata !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL cr_data: core_rdata=%h, expected beef", core_rdata);
      end
      core_req = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (core_rdata !== 16'hBEEF || ldr_rdata !== 16'h0000 || core_ack !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL cr_hold: crd=%h lrd=%h ack=%b busy=%b, expected beef 0000 0 0",
                  core_rdata, ldr_rdata, core_ack, busy);
      end
   endtask

   task automatic test_loader_rw();
      ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h03; ldr_wdata = 16'h00A5;
      @(negedge clk);
      n_tests++;
      if (mem_wr_en !== 1'b1 || mem_addr !== 8'h03 || mem_wdata !== 16'h00A5 || owner !== 1'b1) begin
         n_fail++;
         $display("FAIL lw_issue: wr=%b addr=%h wdata=%h owner=%b, expected 1 03 00a5 1",
                  mem_wr_en, mem_addr, mem_wdata, owner);
      end
      @(negedge clk);
      n_tests++;
      if (ldr_ack !== 1'b1 || core_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL lw_ack: ldr_ack=%b core_ack=%b, expected 1 0", ldr_ack, core_ack);
      end
      ldr_we = 1'b0; ldr_wdata = 16'hFFFF;
      for (int c = 3; c <= 5 + LAT; c++) begin
         @(negedge clk);
         n_tests++;
         if (ldr_ack !== (c == 5 + LAT) || core_ack !== 1'b0 || mem_rd_en !== (c == 4)) begin
            n_fail++;
            $display("FAIL lr_cycle%0d: ldr_ack=%b core_ack=%b rd=%b, expected %b 0 %b",
                     c, ldr_ack, core_ack, mem_rd_en, c == 5 + LAT, c == 4);
         end
      end
      n_tests++;
      if (ldr_rdata !== 16'h00A5 || owner !== 1'b1 || core_rdata !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL lr_data: lrd=%h owner=%b crd=%h, expected 00a5 1 beef", ldr_rdata, owner, core_rdata);
      end
      ldr_req = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || owner !== 1'b1) begin
         n_fail++;
         $display("FAIL lr_idle: busy=%b owner=%b, expected 0 1", busy, owner);
      end
   endtask

   task automatic test_addr_latch();
      core_req = 1'b1; core_we = 1'b0; core_addr = 8'h20; core_wdata = 16'h0000;
      for (int c = 1; c <= 2 + LAT; c++) begin
         @(negedge clk);
         n_tests++;
         if (mem_addr !== 8'h20 || mem_wr_en !== 1'b0 || core_ack !== (c == 2 + LAT)) begin
            n_fail++;
            $display("FAIL latch_cycle%0d: addr=%h wr=%b ack=%b, expected 20 0 %b",
                     c, mem_addr, mem_wr_en, core_ack, c == 2 + LAT);
         end
         if (c == 1) begin
            core_addr = 8'h30; core_wdata = 16'h7777; core_we = 1'b1;
         end
      end
      n_tests++;
      if (core_rdata !== 16'h20DF) begin
         n_fail++;
         $display("FAIL latch_data: core_rdata=%h, expected 20df", core_rdata);
      end
      core_req = 1'b0;
      @(negedge clk);
      n_tests++;
      if (mem_addr !== 8'h20 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL latch_hold: addr=%h busy=%b, expected 20 0", mem_addr, busy);
      end
   endtask

   task automatic test_starvation();
      int order[$];
      int exp_order [6] = '{0, 0, 0, 0, 1, 0};
      int dbl = 0;
      int k = 0;
      core_req = 1'b1; core_we = 1'b1; core_addr = 8'h40; core_wdata = 16'h1000;
      ldr_req  = 1'b1; ldr_we  = 1'b1; ldr_addr  = 8'h50; ldr_wdata  = 16'h2000;
      for (int c = 0; c < 80 && order.size() < 6; c++) begin
         @(negedge clk);
         if (core_ack && ldr_ack) dbl++;
         if (core_ack) begin
            order.push_back(0);
            k++;
            core_addr  = AW'(8'h40 + k);
            core_wdata = DW'(16'h1000 + k);
            if (order.size() == 6) core_req = 1'b0;
         end
         if (ldr_ack) begin
            order.push_back(1);
            ldr_req = 1'b0;
         end
      end
      core_req = 1'b0;
      ldr_req  = 1'b0;
      n_tests++;
      if (dbl != 0) begin
         n_fail++;
         $display("FAIL starve_dual_ack: %0d cycles with both acks, expected 0", dbl);
      end
      n_tests++;
      if (order.size() != 6) begin
         n_fail++;
         $display("FAIL starve_timeout: %0d grants seen, expected 6", order.size());
      end
      for (int i = 0; i < order.size() && i < 6; i++) begin
         n_tests++;
         if (order[i] != exp_order[i]) begin
            n_fail++;
            $display("FAIL starve_order[%0d]: grantee=%0d, expected %0d", i, order[i], exp_order[i]);
         end
      end
      repeat (LAT + 4) @(negedge clk);
   endtask

   task automatic test_reset_in_wait();
      core_req = 1'b1; core_we = 1'b0; core_addr = 8'h12; core_wdata = 16'h0000;
      repeat (2) @(negedge clk);
      n_tests++;
      if (busy !== 1'b1 || mem_rd_en !== 1'b0 || core_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL rw_wait: busy=%b rd=%b ack=%b, expected 1 0 0", busy, mem_rd_en, core_ack);
      end
      reset = 1'b1;
      #1;
      n_tests++;
      if ({core_ack, ldr_ack, mem_rd_en, mem_wr_en, busy, owner} !== 6'b0 ||
          mem_addr !== 8'h00 || mem_wdata !== 16'h0000 ||
          core_rdata !== 16'h0000 || ldr_rdata !== 16'h0000) begin
         n_fail++;
         $display("FAIL rw_async_reset: acks=%b%b rd=%b wr=%b busy=%b owner=%b addr=%h crd=%h lrd=%h, expected all zero",
                  core_ack, ldr_ack, mem_rd_en, mem_wr_en, busy, owner, mem_addr, core_rdata, ldr_rdata);
      end
      core_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < LAT + 3; c++) begin
         @(negedge clk);
         n_tests++;
         if (core_ack !== 1'b0 || ldr_ack !== 1'b0 || busy !== 1'b0 || core_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL rw_no_ack%0d: acks=%b%b busy=%b crd=%h, expected 00 0 0000",
                     c, core_ack, ldr_ack, busy, core_rdata);
         end
      end
      core_req = 1'b1;
      for (int c = 1; c <= 2 + LAT; c++) begin
         @(negedge clk);
         n_tests++;
         if (core_ack !== (c == 2 + LAT) || mem_rd_en !== (c == 1)) begin
            n_fail++;
            $display("FAIL rw_fresh%0d: ack=%b rd=%b, expected %b %b", c, core_ack, mem_rd_en, c == 2 + LAT, c == 1);
         end
      end
      n_tests++;
      if (core_rdata !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL rw_fresh_data: core_rdata=%h, expected beef", core_rdata);
      end
      core_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random(input int ncyc);
      logic [DW-1:0] ref_mem [16];
      logic          s_act [2];
      logic          s_gnt [2];
      logic          s_req [2];
      logic          s_we  [2];
      logic [AW-1:0] s_addr [2];
      logic [DW-1:0] s_wd  [2];
      int            free_at, g_at, strobe_at, ack_at, starve, w;
      logic          t_own, t_we, exp_owner;
      logic [AW-1:0] t_addr, exp_maddr;
      logic [DW-1:0] t_wd, t_rd, exp_crd, exp_lrd;

      reset = 1'b1;
      core_req = 1'b0; ldr_req = 1'b0;
      for (int i = 0; i < 16; i++) ref_mem[i] = mem_init(AW'(8'h60 + i));
      for (int k = 0; k < 2; k++) begin
         s_act[k] = 1'b0; s_gnt[k] = 1'b0; s_req[k] = 1'b0; s_we[k] = 1'b0;
         s_addr[k] = '0; s_wd[k] = '0;
      end
      free_at = 0; g_at = -10; strobe_at = -10; ack_at = -10; starve = 0;
      t_own = 1'b0; t_we = 1'b0; t_addr = '0; t_wd = '0; t_rd = '0;
      exp_owner = 1'b0; exp_maddr = '0; exp_crd = '0; exp_lrd = '0;
      @(negedge clk);
      reset = 1'b0;

      for (int m = 0; m < ncyc; m++) begin
         if (m == g_at + 1) exp_owner = t_own;
         if (m == strobe_at) exp_maddr = t_addr;
         if (m == ack_at && !t_we) begin
            if (t_own) exp_lrd = t_rd;
            else       exp_crd = t_rd;
         end
         n_tests++;
         if (core_ack !== (m == ack_at && !t_own) || ldr_ack !== (m == ack_at && t_own)) begin
            n_fail++;
            $display("FAIL rand_ack@%0d: core_ack=%b ldr_ack=%b, expected %b %b",
                     m, core_ack, ldr_ack, m == ack_at && !t_own, m == ack_at && t_own);
         end
         n_tests++;
         if (mem_wr_en !== (m == strobe_at && t_we) || mem_rd_en !== (m == strobe_at && !t_we)) begin
            n_fail++;
            $display("FAIL rand_strobe@%0d: wr=%b rd=%b, expected %b %b",
                     m, mem_wr_en, mem_rd_en, m == strobe_at && t_we, m == strobe_at && !t_we);
         end
         n_tests++;
         if (mem_addr !== exp_maddr) begin
            n_fail++;
            $display("FAIL rand_addr@%0d: mem_addr=%h, expected %h", m, mem_addr, exp_maddr);
         end
         if (m == strobe_at && t_we) begin
            n_tests++;
            if (mem_wdata !== t_wd) begin
               n_fail++;
               $display("FAIL rand_wdata@%0d: mem_wdata=%h, expected %h", m, mem_wdata, t_wd);
            end
         end
         n_tests++;
         if (busy !== (m > g_at && m <= ack_at) || owner !== exp_owner) begin
            n_fail++;
            $display("FAIL rand_busy_owner@%0d: busy=%b owner=%b, expected %b %b",
                     m, busy, owner, m > g_at && m <= ack_at, exp_owner);
         end
         n_tests++;
         if (core_rdata !== exp_crd || ldr_rdata !== exp_lrd) begin
            n_fail++;
            $display("FAIL rand_rdata@%0d: crd=%h lrd=%h, expected %h %h", m, core_rdata, ldr_rdata, exp_crd, exp_lrd);
         end

         // Requesters: hold until ack, may scramble or drop pins after grant, may give up before grant.
         for (int k = 0; k < 2; k++) begin
            if (s_gnt[k] && m == ack_at) begin
               s_act[k] = 1'b0; s_gnt[k] = 1'b0; s_req[k] = 1'b0;
            end else if (s_gnt[k]) begin
               if ($urandom_range(3) == 0) begin
                  s_req[k]  = 1'($urandom);
                  s_we[k]   = 1'($urandom);
                  s_addr[k] = AW'($urandom);
                  s_wd[k]   = DW'($urandom);
               end
            end else if (s_act[k] && $urandom_range(19) == 0) begin
               s_act[k] = 1'b0; s_req[k] = 1'b0;
            end
            if (!s_act[k] && !s_gnt[k] && $urandom_range(9) < ((m == ack_at) ? 7 : 3)) begin
               s_act[k]  = 1'b1;
               s_req[k]  = 1'b1;
               s_we[k]   = 1'($urandom);
               s_addr[k] = AW'(8'h60 + $urandom_range(15));
               s_wd[k]   = DW'($urandom);
            end
         end
         core_req = s_req[0]; core_we = s_we[0]; core_addr = s_addr[0]; core_wdata = s_wd[0];
         ldr_req  = s_req[1]; ldr_we  = s_we[1]; ldr_addr  = s_addr[1]; ldr_wdata  = s_wd[1];

         // Reference: one access at a time, fixed priority with a loader starvation limit.
         if (m >= free_at) begin
            if (!s_req[1]) starve = 0;
            if (s_req[0] || s_req[1]) begin
               w = (s_req[1] && (!s_req[0] || starve == SMAX)) ? 1 : 0;
               if (w == 1)        starve = 0;
               else if (s_req[1]) starve = (starve < SMAX) ? starve + 1 : starve;
               t_own  = (w == 1);
               t_we   = s_we[w];
               t_addr = s_addr[w];
               t_wd   = s_wd[w];
               s_gnt[w] = 1'b1;
               if (t_we) ref_mem[t_addr[3:0]] = t_wd;
               else      t_rd = ref_mem[t_addr[3:0]];
               g_at      = m;
               strobe_at = m + 1;
               ack_at    = m + 2 + (t_we ? 0 : LAT);
               free_at   = ack_at + 1;
            end
         end
         @(negedge clk);
      end
      core_req = 1'b0;
      ldr_req  = 1'b0;
   endtask

   initial begin
      test_reset();
      test_core_write();
      test_core_read();
      test_loader_rw();
      test_addr_latch();
      test_starvation();
      test_reset_in_wait();
      test_random(3000);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
